// File: rtl/mbm_error_comp_pipe_if.sv
// Handshake and payload bundle for the MBM error-compensation stage.
// The slave modport is the DUT view; the master modport drives it.
interface mbm_error_comp_pipe_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-2:0]     fractional;
    logic             carry;
    logic             mode;
    logic             coef_we;
    logic [N-2:0]     coef_wdata;
    logic             out_valid;
    logic             out_ready;
    logic             c0;
    logic [N:0]       mantissa;
    logic [CNT_W-1:0] sat_count;
    logic [N-2:0]     coef;

    modport slave (
        input  in_valid, fractional, carry, mode, coef_we, coef_wdata, out_ready,
        output in_ready, out_valid, c0, mantissa, sat_count, coef
    );

    modport master (
        output in_valid, fractional, carry, mode, coef_we, coef_wdata, out_ready,
        input  in_ready, out_valid, c0, mantissa, sat_count, coef
    );
endinterface

// File: rtl/mbm_error_comp_pipe.sv
// Two-stage error-compensation stage between the log-adder and antilog shifter:
// adds a programmable (carry-halved) coefficient in MBM mode and forms the mantissa.
module mbm_error_comp_pipe #(
    parameter int unsigned N        = 8,
    parameter int unsigned ERR_COEF = 10,
    parameter int unsigned SAT_TH   = 118,
    parameter int unsigned CNT_W    = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    mbm_error_comp_pipe_if.slave bus
);
    localparam int unsigned FW = N - 1;
    localparam int unsigned MW = N + 1;

    typedef struct packed {
        logic [N-1:0]  sum;
        logic [FW-1:0] frac;
        logic          carry;
        logic          mode;
    } s1_t;

    logic [FW-1:0]    r_coef;
    logic             r_s1_valid;
    s1_t              r_s1;
    logic             r_s2_valid;
    logic             r_c0;
    logic [MW-1:0]    r_mantissa;
    logic [CNT_W-1:0] r_sat_count;

    logic [FW-1:0]    w_corr;
    logic [N-1:0]     w_sum;
    logic             w_s2_adv;
    logic             w_in_ready;
    logic             w_s1_take;
    logic             w_s2_load;
    logic             w_corner;
    logic             w_use_sum;
    logic             w_c0;
    logic [FW-1:0]    w_f;
    logic [MW-1:0]    w_mant;

    // Coefficient is halved when the log-adder produced a carry.
    assign w_corr     = r_coef >> bus.carry;
    assign w_sum      = N'(bus.fractional) + N'(w_corr);

    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;
    assign w_s1_take  = bus.in_valid && w_in_ready;
    assign w_s2_load  = w_s2_adv && r_s1_valid;

    // Near the top of the range the corrected sum would overshoot; pass fractional through.
    assign w_corner   = r_s1.mode && r_s1.carry && (r_s1.frac > FW'(SAT_TH));
    assign w_use_sum  = r_s1.mode && !w_corner;
    assign w_c0       = w_use_sum && r_s1.sum[N-1];
    assign w_f        = w_use_sum ? r_s1.sum[FW-1:0] : r_s1.frac;
    assign w_mant     = w_c0 ? {2'b10, w_f} : {2'b01, w_f};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coef <= FW'(ERR_COEF);
        end else if (bus.coef_we) begin
            r_coef <= bus.coef_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_s1_take) begin
                r_s1.sum   <= w_sum;
                r_s1.frac  <= bus.fractional;
                r_s1.carry <= bus.carry;
                r_s1.mode  <= bus.mode;
            end
        end
    end

    // Output register only changes on advance, so data holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_c0       <= 1'b0;
            r_mantissa <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_c0       <= w_c0;
                r_mantissa <= w_mant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (w_s2_load && w_corner && !(&r_sat_count)) begin
            r_sat_count <= r_sat_count + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.c0        = r_c0;
    assign bus.mantissa  = r_mantissa;
    assign bus.sat_count = r_sat_count;
    assign bus.coef      = r_coef;
endmodule

// File: tb/tb_mbm_error_comp_pipe.sv
// Directed bench for mbm_error_comp_pipe (N=8, 4-bit counter so saturation is reachable).
module tb_mbm_error_comp_pipe;
    localparam int unsigned N     = 8;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mbm_error_comp_pipe_if #(.N(N), .CNT_W(CNT_W)) bus ();

    mbm_error_comp_pipe #(
        .N(N), .ERR_COEF(10), .SAT_TH(118), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated transaction with out_ready held high.
    task automatic xact(input string tag, input logic [6:0] frac, input logic cy, input logic md,
                        input logic exp_c0, input logic [8:0] exp_m);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.fractional = frac;
        bus.carry      = cy;
        bus.mode       = md;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_s1"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_c0"}, 32'(bus.c0), 32'(exp_c0));
        check({tag, "_mant"}, 32'(bus.mantissa), 32'(exp_m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int rcv;
        logic [8:0] held;

        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.fractional = '0;
        bus.carry      = 1'b0;
        bus.mode       = 1'b0;
        bus.coef_we    = 1'b0;
        bus.coef_wdata = '0;
        bus.out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mant", 32'(bus.mantissa), 32'd0);
        check("rst_c0", 32'(bus.c0), 32'd0);
        check("rst_sat", 32'(bus.sat_count), 32'd0);
        check("rst_coef", 32'(bus.coef), 32'd10);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        xact("mbm_c0",    7'h40, 1'b0, 1'b1, 1'b0, 9'h0CA);
        xact("mbm_c1",    7'h40, 1'b1, 1'b1, 1'b0, 9'h0C5);
        xact("ovf",       7'h7C, 1'b0, 1'b1, 1'b1, 9'h106);
        xact("corner",    7'h77, 1'b1, 1'b1, 1'b0, 9'h0F7);
        check("corner_sat", 32'(bus.sat_count), 32'd1);
        xact("nocorner",  7'h76, 1'b1, 1'b1, 1'b0, 9'h0FB);
        check("nocorner_sat", 32'(bus.sat_count), 32'd1);
        xact("mitchell",  7'h7C, 1'b0, 1'b0, 1'b0, 9'h0FC);

        // Coefficient write coinciding with an accepted input.
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.fractional = 7'h40;
        bus.carry      = 1'b0;
        bus.mode       = 1'b1;
        bus.coef_we    = 1'b1;
        bus.coef_wdata = 7'd4;
        @(negedge clk);
        bus.coef_we = 1'b0;
        check("coef_new", 32'(bus.coef), 32'd4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("coef_old_vld", 32'(bus.out_valid), 32'd1);
        check("coef_old_mant", 32'(bus.mantissa), 32'h0CA);
        @(negedge clk);
        check("coef_new_vld", 32'(bus.out_valid), 32'd1);
        check("coef_new_mant", 32'(bus.mantissa), 32'h0C4);

        // Backpressure: stall 5 cycles with a continuous input stream.
        idx  = 0;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.out_ready  = 1'b0;
            bus.in_valid   = 1'b1;
            bus.fractional = 7'(8'h10 + idx);
            #1;
            if (c == 2) begin
                check("bp_first_vld", 32'(bus.out_valid), 32'd1);
                check("bp_first_mant", 32'(bus.mantissa), 32'h094);
                held = bus.mantissa;
            end else if (c > 2) begin
                check("bp_hold_mant", 32'(bus.mantissa), 32'(held));
            end
            if (bus.in_ready) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);

        rcv = 0;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            @(negedge clk);
            bus.out_ready  = 1'b1;
            bus.in_valid   = (idx < 6);
            bus.fractional = 7'(8'h10 + idx);
            #1;
            if (c == 0) check("bp_release_ready", 32'(bus.in_ready), 32'd1);
            if (bus.out_valid) begin
                check("bp_order", 32'(bus.mantissa), 32'(9'h094 + 9'(rcv)));
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
        end
        bus.in_valid = 1'b0;
        check("bp_received", 32'(rcv), 32'd6);

        // Saturation: 20 more corner hits on a 4-bit counter already at 1.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.fractional = 7'h7F;
            bus.carry      = 1'b1;
            bus.mode       = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("sat_hold", 32'(bus.sat_count), 32'd15);
        check("sat_mant", 32'(bus.mantissa), 32'h0FF);

        // Reset mid-stream.
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.fractional = 7'h40;
        bus.carry      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid_vld", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
        check("mid_rst_sat", 32'(bus.sat_count), 32'd0);
        check("mid_rst_coef", 32'(bus.coef), 32'd10);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_vld", 32'(bus.out_valid), 32'd0);
        end
        xact("post_rst", 7'h40, 1'b0, 1'b1, 1'b0, 9'h0CA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
